button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000; consecutive stable synchronized samples required to accept a level change (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter LONG_CYCLES, default 50000000; PRESSED-state cycles before a long-press event (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
REQ-003 SHALL have port Clock, input, 1, the single system clock; all flops on its rising edge.
REQ-004 SHALL have port Resetn, input, 1, reset; asynchronous assert, active-low.
REQ-005 SHALL have port Pushn, input, 1, raw active-low pushbutton; asynchronous and bouncing.
REQ-006 SHALL have port Pressed, output, 1, debounced level; 1 while the button is accepted as held.
REQ-007 SHALL have port PressPulse, output, 1, one-cycle strobe on an accepted press.
REQ-008 SHALL have port ReleasePulse, output, 1, one-cycle strobe on an accepted release.
REQ-009 SHALL have port LongPulse, output, 1, one-cycle strobe when a press reaches LONG_CYCLES.
REQ-010 SHALL have port PressCount, output, 8, count of accepted presses.

Function
REQ-011 Pushn SHALL pass through a two-flop synchronizer; synchronized value s only is used downstream.
REQ-012 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-013 IDLE: s=0 -> PRESS_WAIT with debounce count 1; s=1 -> stay.
REQ-014 PRESS_WAIT: s=1 -> IDLE, count cleared; s=0 -> count+1; on the edge count reaches DEBOUNCE_CYCLES -> PRESSED.
REQ-015 PressPulse SHALL be high exactly one cycle, the first cycle in PRESSED entered from PRESS_WAIT; latency DEBOUNCE_CYCLES+2 rising edges from the first edge sampling a stable low Pushn.
REQ-016 PRESSED: s=1 -> RELEASE_WAIT with count 1; long counter increments every PRESSED cycle.
REQ-017 LongPulse SHALL be high one cycle when long counter reaches LONG_CYCLES; long counter then saturates; at most one LongPulse per press.
REQ-018 RELEASE_WAIT: s=0 -> PRESSED without PressPulse, long counter retained (held, not cleared, not incremented); s=1 -> count+1; on reaching DEBOUNCE_CYCLES -> IDLE.
REQ-019 ReleasePulse SHALL be high one cycle, the first cycle in IDLE entered from RELEASE_WAIT; long counter cleared on that transition.
REQ-020 Pressed SHALL be 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT.
REQ-021 PressCount SHALL increment in the same cycle PressPulse is high; 255 wraps to 0.
REQ-022 Debounce counter SHALL never exceed DEBOUNCE_CYCLES; no wrap.
REQ-023 PressPulse, ReleasePulse, LongPulse SHALL be registered outputs, never simultaneously high.

Reset
REQ-024 Resetn low SHALL asynchronously force IDLE, both counters 0, PressCount 0, all pulses 0, Pressed 0, synchronizer flops 1 (released).
REQ-025 Reset asserted mid-press SHALL discard the press without any pulse; if Pushn is still low after release of Resetn, a new press SHALL be accepted per REQ-013..015.

Structure
REQ-026 Shared package SHALL hold the state enumeration and default DEBOUNCE_CYCLES/LONG_CYCLES constants.
REQ-027 The synchronizer SHALL be a separate sub-module sync2 (two flops, async active-low reset to a parameterized value).
REQ-028 Counter widths SHALL be derived from parameters, no hard-coded widths beyond PressCount.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20)
REQ-029 Clean press: Pushn 1->0 held -> PressPulse one cycle exactly 6 edges after first low sample, Pressed=1, PressCount=1.
REQ-030 Bounce: Pushn low 3 cycles then high, repeated 5 times -> no PressPulse, Pressed=0, PressCount=0.
REQ-031 Long press: Pushn low 40 cycles -> one PressPulse, one LongPulse 20 PRESSED cycles later, then release -> one ReleasePulse 6 edges after Pushn rises.
REQ-032 Release bounce: while PRESSED, Pushn high 2 cycles then low -> no ReleasePulse, no second PressPulse, Pressed stays 1.
REQ-033 Wrap: 256 clean presses -> PressCount returns to 0 on 256th PressPulse.
REQ-034 Reset mid-press: Resetn low during PRESS_WAIT and during PRESSED -> all outputs 0 asynchronously; Pushn held low through reset release -> PressPulse 6 edges after release.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and default timing constants
// for the pushbutton conditioner.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  // 10 ms and 1 s at a 50 MHz system clock
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned LONG_CYCLES_DEF     = 50000000;

endpackage

// File: rtl/button_conditioner_sync2.sv
// Two-flop synchronizer with async active-low
// reset to a selectable idle level.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // metastability filter: two back-to-back flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounces an active-low pushbutton and emits
// press, release and long-press strobes.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Pushn,
  output logic       Pressed,
  output logic       PressPulse,
  output logic       ReleasePulse,
  output logic       LongPulse,
  output logic [7:0] PressCount
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [LW-1:0] LG_MAX = LW'(LONG_CYCLES);

  logic s;

  state_e        state_q, state_d;
  logic [DW-1:0] db_q, db_d;
  logic [LW-1:0] long_q, long_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          pressed_q, pressed_d;
  logic          pp_q, pp_d;
  logic          rp_q, rp_d;
  logic          lp_q, lp_d;

  sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (Clock),
    .rst_n (Resetn),
    .d     (Pushn),
    .q     (s)
  );

  // next-state, counters and strobes
  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    long_d  = long_q;
    cnt_d   = cnt_q;
    pp_d    = 1'b0;
    rp_d    = 1'b0;
    lp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!s) begin
          state_d = PRESS_WAIT;
          db_d    = DW'(1);
        end
      end
      PRESS_WAIT: begin
        if (s) begin
          state_d = IDLE;
          db_d    = '0;
        end else if (db_q + DW'(1) == DB_MAX) begin
          state_d = PRESSED;
          db_d    = '0;
          pp_d    = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      PRESSED: begin
        if (long_q != LG_MAX) begin
          long_d = long_q + LW'(1);
          lp_d   = (long_q + LW'(1) == LG_MAX);
        end
        if (s) begin
          state_d = RELEASE_WAIT;
          db_d    = DW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!s) begin
          state_d = PRESSED;
          db_d    = '0;
        end else if (db_q + DW'(1) == DB_MAX) begin
          state_d = IDLE;
          db_d    = '0;
          long_d  = '0;
          rp_d    = 1'b1;
        end else begin
          db_d = db_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        db_d    = '0;
        long_d  = '0;
      end
    endcase
    pressed_d = (state_d == PRESSED) ||
                (state_d == RELEASE_WAIT);
  end

  // state, counters and registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= IDLE;
      db_q      <= '0;
      long_q    <= '0;
      cnt_q     <= '0;
      pressed_q <= 1'b0;
      pp_q      <= 1'b0;
      rp_q      <= 1'b0;
      lp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      db_q      <= db_d;
      long_q    <= long_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      pp_q      <= pp_d;
      rp_q      <= rp_d;
      lp_q      <= lp_d;
    end
  end

  assign Pressed      = pressed_q;
  assign PressPulse   = pp_q;
  assign ReleasePulse = rp_q;
  assign LongPulse    = lp_q;
  assign PressCount   = cnt_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner:
// timed pulse events are queued and matched.
module tb_button_conditioner;

  localparam int DB = 4;
  localparam int LG = 20;

  typedef struct {
    int kind;
    int cyc;
    int cnt;
  } ev_t;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic       Pushn;
  logic       Pressed;
  logic       PressPulse;
  logic       ReleasePulse;
  logic       LongPulse;
  logic [7:0] PressCount;

  ev_t sb[$];
  ev_t mon_e;
  int  mon_k;
  int  cyc     = 0;
  int  checks  = 0;
  int  errors  = 0;
  int  exp_cnt = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG)
  ) dut (
    .Clock        (Clock),
    .Resetn       (Resetn),
    .Pushn        (Pushn),
    .Pressed      (Pressed),
    .PressPulse   (PressPulse),
    .ReleasePulse (ReleasePulse),
    .LongPulse    (LongPulse),
    .PressCount   (PressCount)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int at, input int cnt);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.cnt  = cnt;
    sb.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // called on a falling edge: first sampling edge is cyc+1
  task automatic press();
    Pushn   = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    push(0, cyc + DB + 2, exp_cnt);
  endtask

  task automatic rel();
    Pushn = 1'b1;
    push(1, cyc + DB + 2, 0);
  endtask

  // match every strobe against the oldest queued event
  always @(negedge Clock) begin
    if (PressPulse || ReleasePulse || LongPulse) begin
      mon_k = PressPulse ? 0 : (ReleasePulse ? 1 : 2);
      chk("excl", $countones({PressPulse, ReleasePulse, LongPulse}), 1);
      if (sb.size() == 0) begin
        chk("unexp_pulse", mon_k, -1);
      end else begin
        mon_e = sb.pop_front();
        chk("kind", mon_k, mon_e.kind);
        chk("when", cyc, mon_e.cyc);
        if (mon_k == 0) chk("cnt", int'(PressCount), mon_e.cnt);
      end
    end
  end

  initial begin
    Resetn = 1'b0;
    Pushn  = 1'b1;
    wait_n(3);
    chk("rst_pressed", Pressed, 0);
    chk("rst_pp", PressPulse, 0);
    chk("rst_rp", ReleasePulse, 0);
    chk("rst_lp", LongPulse, 0);
    chk("rst_cnt", int'(PressCount), 0);
    Resetn = 1'b1;
    wait_n(3);

    // bounce shorter than the debounce window
    repeat (5) begin
      Pushn = 1'b0;
      wait_n(3);
      Pushn = 1'b1;
      wait_n(3);
    end
    wait_n(6);
    chk("bnc_pressed", Pressed, 0);
    chk("bnc_cnt", int'(PressCount), 0);

    // clean press and release
    press();
    wait_n(10);
    chk("clean_pressed", Pressed, 1);
    chk("clean_cnt", int'(PressCount), 1);
    rel();
    wait_n(10);
    chk("clean_rel", Pressed, 0);

    // long press
    press();
    push(2, cyc + DB + 2 + LG, 0);
    wait_n(40);
    chk("long_pressed", Pressed, 1);
    rel();
    wait_n(12);
    chk("long_rel", Pressed, 0);

    // release bounce while held
    press();
    wait_n(10);
    Pushn = 1'b1;
    wait_n(2);
    Pushn = 1'b0;
    repeat (8) begin
      wait_n(1);
      chk("relb_pressed", Pressed, 1);
    end
    rel();
    wait_n(10);
    chk("relb_rel", Pressed, 0);
    chk("relb_cnt", int'(PressCount), 3);

    // reset during PRESS_WAIT
    Pushn = 1'b0;
    wait_n(4);
    #2 Resetn = 1'b0;
    #1;
    chk("rpw_pressed", Pressed, 0);
    chk("rpw_cnt", int'(PressCount), 0);
    exp_cnt = 0;
    wait_n(2);
    Resetn  = 1'b1;
    exp_cnt = 1;
    push(0, cyc + DB + 2, 1);
    wait_n(10);
    chk("rpw_repress", Pressed, 1);

    // reset during PRESSED
    #2 Resetn = 1'b0;
    #1;
    chk("rpr_pressed", Pressed, 0);
    chk("rpr_cnt", int'(PressCount), 0);
    chk("rpr_pp", PressPulse, 0);
    wait_n(2);
    Resetn  = 1'b1;
    exp_cnt = 1;
    push(0, cyc + DB + 2, 1);
    wait_n(10);
    chk("rpr_repress", Pressed, 1);
    chk("rpr_cnt2", int'(PressCount), 1);
    rel();
    wait_n(10);

    // 256 presses wrap the counter
    Resetn = 1'b0;
    wait_n(2);
    Resetn  = 1'b1;
    exp_cnt = 0;
    wait_n(2);
    for (int i = 0; i < 256; i++) begin
      press();
      wait_n(8);
      rel();
      wait_n(8);
    end
    chk("wrap_cnt", int'(PressCount), 0);

    wait_n(10);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
